amo_sequencer: RTL and testbench

Multi-cycle controller that executes RV32A atomics (LR.W, SC.W, AMO*.W) on behalf of the core's control unit. It owns the read-modify-write sequence on the data memory port, steers ALUOp/AMOop and the operands into the shared ALU/alu_decoder, and keeps the LR/SC reservation. It sits between the main control FSM and the memory interface and is active only while an atomic instruction is in flight.

---
 rtl/amo_sequencer_pkg.sv | 35 +++
 rtl/amo_reservation.sv | 31 +++
 rtl/amo_sequencer.sv | 156 +++++++++++++++
 tb/tb_amo_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amo_sequencer_pkg.sv
// Shared encodings for the RV32A atomic sequencer: ALU/AMO op codes, SC result codes and
// the sequencer state type.
package amo_sequencer_pkg;

    localparam int unsigned AMO_OP_WIDTH = 5;
    localparam int unsigned ALU_OP_WIDTH = 4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AMO = 4'd10;

    // AMO codes follow the RV32A funct5 field
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_ADD  = 5'b00000;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_SWAP = 5'b00001;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_LR   = 5'b00010;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_SC   = 5'b00011;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_XOR  = 5'b00100;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_OR   = 5'b01000;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_AND  = 5'b01100;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MIN  = 5'b10000;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MAX  = 5'b10100;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MINU = 5'b11000;
    localparam logic [AMO_OP_WIDTH-1:0] AMO_OP_MAXU = 5'b11100;

    localparam int unsigned SC_SUCCESS = 0;
    localparam int unsigned SC_FAIL    = 1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCalc,
        StWrite,
        StDone
    } amo_state_t;

endpackage

// File: rtl/amo_reservation.sv
// LR/SC reservation: one valid bit plus the reserved granule tag. Clear has priority over set.
module amo_reservation #(
    parameter int unsigned TAG_WIDTH = 30
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 set,
    input  logic                 clear,
    input  logic [TAG_WIDTH-1:0] set_tag,
    input  logic [TAG_WIDTH-1:0] match_tag,
    output logic                 match
);

    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            tag   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (set) begin
            valid <= 1'b1;
            tag   <= set_tag;
        end
    end

    assign match = valid && (tag == match_tag);

endmodule

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: runs the LR/SC/AMO read-modify-write on the data port and steers
// the shared ALU during the single compute cycle.
module amo_sequencer
    import amo_sequencer_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned RESV_GRANULE_LSB = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    amo_valid,
    output logic                    amo_ready,
    input  logic [AMO_OP_WIDTH-1:0] amo_op,
    input  logic [XLEN-1:0]         amo_addr,
    input  logic [XLEN-1:0]         amo_rs2,
    input  logic                    resv_clear,
    output logic                    done,
    output logic [XLEN-1:0]         rd_data,
    output logic                    fault,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [3:0]              mem_wstrb,
    output logic [XLEN-1:0]         mem_addr,
    output logic [XLEN-1:0]         mem_wdata,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [AMO_OP_WIDTH-1:0] alu_amo_op,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    input  logic [XLEN-1:0]         alu_result
);

    localparam int unsigned TagWidth = XLEN - RESV_GRANULE_LSB;

    amo_state_t              state;
    logic [AMO_OP_WIDTH-1:0] op;
    logic [XLEN-1:0]         rs2;
    logic [XLEN-1:0]         old_val;
    logic                    aligned;
    logic                    accept;
    logic                    resv_set;
    logic                    resv_clr;
    logic                    resv_match;

    assign amo_ready = (state == StIdle);
    assign accept    = amo_ready && amo_valid;
    assign aligned   = (amo_addr[1:0] == 2'b00);
    assign resv_set  = (state == StRead) && mem_ready && (op == AMO_OP_LR);
    // Any aligned SC consumes the reservation, pass or fail
    assign resv_clr  = resv_clear || (accept && aligned && (amo_op == AMO_OP_SC));

    amo_reservation #(
        .TAG_WIDTH(TagWidth)
    ) u_reservation (
        .clk      (clk),
        .resetn   (resetn),
        .set      (resv_set),
        .clear    (resv_clr),
        .set_tag  (mem_addr[XLEN-1:RESV_GRANULE_LSB]),
        .match_tag(amo_addr[XLEN-1:RESV_GRANULE_LSB]),
        .match    (resv_match)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            op         <= '0;
            rs2        <= '0;
            old_val    <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            rd_data    <= '0;
            mem_valid  <= 1'b0;
            mem_wstrb  <= 4'h0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            alu_op     <= ALU_OP_ADD;
            alu_amo_op <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (amo_valid) begin
                        op  <= amo_op;
                        rs2 <= amo_rs2;
                        if (!aligned) begin
                            fault   <= 1'b1;
                            rd_data <= '0;
                            done    <= 1'b1;
                            state   <= StDone;
                        end else if (amo_op == AMO_OP_SC) begin
                            if (resv_match) begin
                                mem_valid <= 1'b1;
                                mem_wstrb <= 4'hF;
                                mem_addr  <= {amo_addr[XLEN-1:2], 2'b00};
                                mem_wdata <= amo_rs2;
                                state     <= StWrite;
                            end else begin
                                rd_data <= XLEN'(SC_FAIL);
                                done    <= 1'b1;
                                state   <= StDone;
                            end
                        end else begin
                            mem_valid <= 1'b1;
                            mem_wstrb <= 4'h0;
                            mem_addr  <= {amo_addr[XLEN-1:2], 2'b00};
                            state     <= StRead;
                        end
                    end
                end
                StRead: begin
                    if (mem_ready) begin
                        old_val   <= mem_rdata;
                        mem_valid <= 1'b0;
                        if (op == AMO_OP_LR) begin
                            rd_data <= mem_rdata;
                            done    <= 1'b1;
                            state   <= StDone;
                        end else begin
                            alu_op     <= ALU_OP_AMO;
                            alu_amo_op <= op;
                            alu_a      <= mem_rdata;
                            alu_b      <= rs2;
                            state      <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    // mem_wdata is the registered new value; SWAP does not use the ALU
                    mem_wdata <= (op == AMO_OP_SWAP) ? rs2 : alu_result;
                    alu_op    <= ALU_OP_ADD;
                    mem_valid <= 1'b1;
                    mem_wstrb <= 4'hF;
                    state     <= StWrite;
                end
                StWrite: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'h0;
                        rd_data   <= (op == AMO_OP_SC) ? XLEN'(SC_SUCCESS) : old_val;
                        done      <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// Bench for amo_sequencer: directed RV32A cases plus random ops checked against a word-level
// model of memory and the LR/SC reservation; a stub ALU and a stalling memory sit around the DUT.
module tb_amo_sequencer;
    import amo_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        amo_valid, amo_ready, resv_clear, done, fault;
    logic [4:0]  amo_op, alu_amo_op;
    logic [31:0] amo_addr, amo_rs2, rd_data;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [3:0]  mem_wstrb, alu_op;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] alu_a, alu_b, alu_result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int reads = 0;
    int writes = 0;
    int valid_cycles = 0;
    int wait_cfg = 0;
    int stall_left = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr, pend_wdata;
    logic [3:0]  pend_wstrb;
    bit          poke_en = 1'b0;
    logic [7:0]  poke_idx = 8'h0;
    logic [31:0] poke_data = 32'h0;

    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];
    bit          resv_valid = 1'b0;
    logic [29:0] resv_word = '0;

    always #5 clk = ~clk;

    amo_sequencer dut (
        .clk       (clk),
        .resetn    (resetn),
        .amo_valid (amo_valid),
        .amo_ready (amo_ready),
        .amo_op    (amo_op),
        .amo_addr  (amo_addr),
        .amo_rs2   (amo_rs2),
        .resv_clear(resv_clear),
        .done      (done),
        .rd_data   (rd_data),
        .fault     (fault),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .alu_op    (alu_op),
        .alu_amo_op(alu_amo_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_result(alu_result)
    );

    function automatic logic [31:0] amo_math(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            AMO_OP_XOR:  return a ^ b;
            AMO_OP_OR:   return a | b;
            AMO_OP_AND:  return a & b;
            AMO_OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
            AMO_OP_MAX:  return ($signed(a) > $signed(b)) ? a : b;
            AMO_OP_MINU: return (a < b) ? a : b;
            AMO_OP_MAXU: return (a > b) ? a : b;
            default:     return a + b;
        endcase
    endfunction

    // Stub decoder: SWAP yields garbage so only a bypassing sequencer gets it right
    assign alu_result = (alu_op != ALU_OP_AMO) ? alu_a + alu_b :
                        (alu_amo_op == AMO_OP_SWAP) ? ~alu_b : amo_math(alu_amo_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (poke_en) mem[poke_idx] <= poke_data;
        if (resetn && mem_valid && mem_ready) begin
            if (mem_wstrb == 4'hF) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                writes       <= writes + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wdata;
            end else begin
                reads <= reads + 1;
            end
        end
    end

    // Memory responder with configurable stall; also watches request stability while stalled
    always @(negedge clk) begin
        if (!resetn) begin
            pend       <= 1'b0;
            mem_ready  <= 1'b0;
            stall_left <= wait_cfg;
        end else begin
            if (pend) begin
                chk("stall_valid", 32'(mem_valid), 32'd1);
                chk("stall_addr", mem_addr, pend_addr);
                chk("stall_wdata", mem_wdata, pend_wdata);
                chk("stall_wstrb", 32'(mem_wstrb), 32'(pend_wstrb));
            end
            if (mem_valid) begin
                valid_cycles <= valid_cycles + 1;
                if (stall_left > 0) begin
                    mem_ready  <= 1'b0;
                    stall_left <= stall_left - 1;
                    pend       <= 1'b1;
                    pend_addr  <= mem_addr;
                    pend_wdata <= mem_wdata;
                    pend_wstrb <= mem_wstrb;
                end else begin
                    mem_ready <= 1'b1;
                    mem_rdata <= mem[mem_addr[9:2]];
                    pend      <= 1'b0;
                end
            end else begin
                mem_ready  <= 1'($urandom_range(0, 1));
                mem_rdata  <= $urandom;
                stall_left <= wait_cfg;
                pend       <= 1'b0;
            end
        end
    end

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        poke_idx  = addr[9:2];
        poke_data = data;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
        exp_mem[addr[9:2]] = data;
    endtask

    task automatic model(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input int w, input bit clr, output logic [31:0] e_rd,
                         output logic e_fault, output int e_lat, output int e_reads,
                         output int e_writes, output logic [31:0] e_wdata);
        logic [31:0] old;
        e_rd = 32'h0;
        e_fault = 1'b0;
        e_reads = 0;
        e_writes = 0;
        e_wdata = 32'h0;
        if (addr[1:0] != 2'b00) begin
            e_fault = 1'b1;
            e_lat = 2;
        end else if (op == AMO_OP_SC) begin
            if (resv_valid && resv_word == addr[31:2]) begin
                e_writes = 1;
                e_wdata = rs2;
                exp_mem[addr[9:2]] = rs2;
                e_lat = 3 + w;
            end else begin
                e_rd = 32'd1;
                e_lat = 2;
            end
            resv_valid = 1'b0;
        end else if (op == AMO_OP_LR) begin
            e_reads = 1;
            e_rd = exp_mem[addr[9:2]];
            resv_valid = 1'b1;
            resv_word = addr[31:2];
            e_lat = 3 + w;
        end else begin
            old = exp_mem[addr[9:2]];
            e_reads = 1;
            e_writes = 1;
            e_rd = old;
            e_wdata = (op == AMO_OP_SWAP) ? rs2 : amo_math(op, old, rs2);
            exp_mem[addr[9:2]] = e_wdata;
            e_lat = 5 + 2 * w;
        end
        // A clear in the first cycle after accept precedes a stalled LR's reservation set
        if (clr && !(op == AMO_OP_LR && addr[1:0] == 2'b00 && w > 0)) resv_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        amo_valid = 1'b0;
        resv_clear = 1'b0;
        wait_cfg = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        resv_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input int w, input bit clr);
        logic [31:0] e_rd, e_wdata;
        logic        e_fault;
        int          e_lat, e_reads, e_writes, acc, rd0, wr0, vc0, dcyc;
        bit          got;
        model(op, addr, rs2, w, clr, e_rd, e_fault, e_lat, e_reads, e_writes, e_wdata);
        wait_cfg = w;
        @(negedge clk);
        chk("ready_idle", 32'(amo_ready), 32'd1);
        rd0 = reads;
        wr0 = writes;
        vc0 = valid_cycles;
        acc = cyc;
        amo_op = op;
        amo_addr = addr;
        amo_rs2 = rs2;
        amo_valid = 1'b1;
        @(negedge clk);
        amo_valid = 1'b0;
        resv_clear = clr;
        got = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 1) resv_clear = 1'b0;
            if (done) begin
                got = 1'b1;
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            chk("latency", 32'(dcyc - acc + 1), 32'(e_lat));
            chk("rd_data", rd_data, e_rd);
            chk("fault", 32'(fault), 32'(e_fault));
        end
        @(negedge clk);
        resv_clear = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("reads", 32'(reads - rd0), 32'(e_reads));
        chk("writes", 32'(writes - wr0), 32'(e_writes));
        if (e_writes == 1) begin
            chk("wr_data", last_wr_data, e_wdata);
            chk("wr_addr", last_wr_addr, {addr[31:2], 2'b00});
        end
        if (e_reads == 0 && e_writes == 0) chk("no_mem_valid", 32'(valid_cycles - vc0), 32'd0);
        if (!got) do_reset();
    endtask

    task automatic pulse_clear();
        resv_clear = 1'b1;
        @(negedge clk);
        resv_clear = 1'b0;
        resv_valid = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ops [12];
        logic [4:0]  op, last_op;
        logic [31:0] addr, last_addr;
        int          w0;
        bit          got;
        ops = '{AMO_OP_ADD, AMO_OP_SWAP, AMO_OP_LR, AMO_OP_SC, AMO_OP_XOR, AMO_OP_OR,
                AMO_OP_AND, AMO_OP_MIN, AMO_OP_MAX, AMO_OP_MINU, AMO_OP_MAXU, 5'b00101};
        amo_valid = 1'b0;
        amo_op = '0;
        amo_addr = '0;
        amo_rs2 = '0;
        resv_clear = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready", 32'(amo_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
        chk("rst_alu_amo_op", 32'(alu_amo_op), 32'd0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) poke(32'h100 + 32'(4 * i), $urandom);
        poke(32'h100, 32'd5);
        poke(32'h200, 32'hA);
        poke(32'h204, 32'h1234);

        do_op(AMO_OP_ADD, 32'h100, 32'd3, 0, 1'b0);
        do_op(AMO_OP_LR, 32'h200, 32'h0, 0, 1'b0);
        do_op(AMO_OP_SC, 32'h200, 32'h55, 0, 1'b0);
        do_op(AMO_OP_SC, 32'h200, 32'h66, 0, 1'b0);
        do_op(AMO_OP_LR, 32'h200, 32'h0, 0, 1'b0);
        pulse_clear();
        do_op(AMO_OP_SC, 32'h200, 32'h77, 0, 1'b0);
        do_op(AMO_OP_LR, 32'h200, 32'h0, 0, 1'b0);
        do_op(AMO_OP_SC, 32'h204, 32'h88, 0, 1'b0);
        do_op(AMO_OP_LR, 32'h200, 32'h0, 0, 1'b1);
        do_op(AMO_OP_SC, 32'h200, 32'h99, 0, 1'b0);

        poke(32'h104, 32'hFFFF_FFFF);
        do_op(AMO_OP_MAXU, 32'h104, 32'd1, 0, 1'b0);
        poke(32'h108, 32'hFFFF_FFFF);
        do_op(AMO_OP_MIN, 32'h108, 32'd1, 0, 1'b0);
        poke(32'h10C, 32'd7);
        do_op(AMO_OP_SWAP, 32'h10C, 32'd9, 0, 1'b0);
        do_op(AMO_OP_OR, 32'h102, 32'hF0, 0, 1'b0);
        do_op(5'b00101, 32'h110, 32'd100, 0, 1'b0);
        do_op(AMO_OP_ADD, 32'h114, 32'h1111, 4, 1'b0);
        do_op(AMO_OP_LR, 32'h118, 32'h0, 4, 1'b0);
        do_op(AMO_OP_SC, 32'h118, 32'hCAFE, 4, 1'b0);

        // Reset while a write is stalled: the write must be abandoned
        wait_cfg = 10;
        @(negedge clk);
        amo_op = AMO_OP_ADD;
        amo_addr = 32'h11C;
        amo_rs2 = 32'd1;
        amo_valid = 1'b1;
        @(negedge clk);
        amo_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mem_valid && mem_wstrb == 4'hF) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reach_write", 32'(got), 32'd1);
        w0 = writes;
        #2 resetn = 1'b0;
        #1;
        chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
        chk("midrst_ready", 32'(amo_ready), 32'd1);
        chk("midrst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        resv_valid = 1'b0;
        wait_cfg = 0;
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_no_write", 32'(writes - w0), 32'd0);
        do_op(AMO_OP_ADD, 32'h11C, 32'd2, 0, 1'b0);

        last_op = AMO_OP_ADD;
        last_addr = 32'h100;
        for (int n = 0; n < 60; n++) begin
            if (last_op == AMO_OP_LR && $urandom_range(0, 1) == 1) begin
                op = AMO_OP_SC;
                addr = last_addr;
            end else begin
                op = ops[$urandom_range(0, 11)];
                addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) addr = addr | 32'($urandom_range(1, 3));
            end
            do_op(op, addr, $urandom, $urandom_range(0, 2), $urandom_range(0, 7) == 0);
            last_op = op;
            last_addr = addr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
